wb_arbiter: RTL

Writeback arbiter in front of the register file's single write port. Merges single-cycle results from the main pipeline's MEM/WB stage with results from the multi-cycle mul/div unit, buffers mul/div results in a small FIFO, and drives the register file's write-enable/address/data from registered outputs. Pipeline results have priority; a starvation counter forces a mul/div drain by stalling the pipeline one cycle.

---
 rtl/wb_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the register file's single write port.
// Merges single-cycle pipeline results with buffered mul/div results.
// Pipeline has priority; a starvation counter forces a FIFO drain by
// stalling the pipeline for one cycle.
//
// Optional feature macro: WB_LOAD_ALIGN_EN (load byte/half extraction and
// sign/zero extension on pipeline load results).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   WB_pipe_*              pipeline writeback request and load attributes
//   WB_stall_pipe          combinational: pipeline request not accepted
//   MD_valid/addr/data     mul/div result offer
//   MD_ready               combinational: FIFO not full
//   REG_write_1            registered register-file write enable
//   REG_address_wr         registered register-file write address
//   REG_data_wb_in1        registered register-file write data
module wb_arbiter #(
    parameter int unsigned MD_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        WB_pipe_valid,
    input  logic [4:0]  WB_pipe_addr,
    input  logic [31:0] WB_pipe_data,
    input  logic        WB_pipe_is_load,
    input  logic [1:0]  WB_pipe_ld_size,
    input  logic        WB_pipe_ld_unsigned,
    input  logic [1:0]  WB_pipe_byte_off,
    output logic        WB_stall_pipe,
    input  logic        MD_valid,
    input  logic [4:0]  MD_addr,
    input  logic [31:0] MD_data,
    output logic        MD_ready,
    output logic        REG_write_1,
    output logic [4:0]  REG_address_wr,
    output logic [31:0] REG_data_wb_in1
);

    localparam int unsigned AW = $clog2(MD_FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned EW = 37;

    logic [EW-1:0] r_fifo [MD_FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_starve;
    logic          r_we;
    logic [4:0]    r_addr;
    logic [31:0]   r_data;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_force;
    logic          w_grant_md;
    logic          w_grant_pipe;
    logic [4:0]    w_head_addr;
    logic [31:0]   w_head_data;
    logic [31:0]   w_pipe_data;

    // FIFO status: pointers carry one wrap bit beyond the index
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push  = MD_valid && !w_full;
    assign {w_head_addr, w_head_data} = r_fifo[r_rd_ptr[AW-1:0]];

    // Grant: a saturated starvation counter beats the pipeline
    assign w_force      = (r_starve == CW'(STARVE_LIMIT)) && !w_empty;
    assign w_grant_pipe = WB_pipe_valid && !w_force;
    assign w_grant_md   = w_force || (!WB_pipe_valid && !w_empty);

    assign WB_stall_pipe = w_force && WB_pipe_valid;
    assign MD_ready      = !w_full;

`ifdef WB_LOAD_ALIGN_EN
    logic [31:0] w_shifted;
    logic        w_sign;

    // Load alignment: shift the addressed lane down, then extend
    always_comb begin
        w_shifted   = WB_pipe_data;
        w_sign      = 1'b0;
        w_pipe_data = WB_pipe_data;
        if (WB_pipe_is_load) begin
            case (WB_pipe_ld_size)
                2'b00: begin
                    w_shifted   = WB_pipe_data >> {WB_pipe_byte_off, 3'b000};
                    w_sign      = !WB_pipe_ld_unsigned && w_shifted[7];
                    w_pipe_data = {{24{w_sign}}, w_shifted[7:0]};
                end
                2'b01: begin
                    w_shifted   = WB_pipe_data >> {WB_pipe_byte_off[1], 4'b0000};
                    w_sign      = !WB_pipe_ld_unsigned && w_shifted[15];
                    w_pipe_data = {{16{w_sign}}, w_shifted[15:0]};
                end
                default: w_pipe_data = WB_pipe_data;
            endcase
        end
    end
`else
    logic w_unused_load;

    // Load attributes have no effect in this build
    assign w_unused_load = WB_pipe_is_load ^ ^WB_pipe_ld_size ^
                           WB_pipe_ld_unsigned ^ ^WB_pipe_byte_off;
    assign w_pipe_data   = WB_pipe_data;
`endif

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= {MD_addr, MD_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_grant_md) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Starvation counter: counts cycles a waiting head is passed over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_grant_md) begin
            r_starve <= '0;
        end else if (!w_empty && (r_starve != CW'(STARVE_LIMIT))) begin
            r_starve <= r_starve + CW'(1);
        end
    end

    // Write-port register; address 0 is consumed without writing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_grant_pipe) begin
                r_we   <= (WB_pipe_addr != 5'd0);
                r_addr <= WB_pipe_addr;
                r_data <= w_pipe_data;
            end else if (w_grant_md) begin
                r_we   <= (w_head_addr != 5'd0);
                r_addr <= w_head_addr;
                r_data <= w_head_data;
            end
        end
    end

    assign REG_write_1     = r_we;
    assign REG_address_wr  = r_addr;
    assign REG_data_wb_in1 = r_data;

endmodule
